// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate data
// cache with an integrated miss controller and uncached word path.
// Ports:
//   clk, reset            clock, async active-high reset
//   data_sram_*           CPU memory-stage bus (en/we/addr/wdata in,
//                         rdata out), dcache_uncached bypass select
//   stallreq_dcache       CPU must hold its request while high
//   mem_rd_*              line refill / single-word read handshake
//   mem_wr_*              victim write-back / single-word write handshake
module dcache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 16,
    localparam int LINE_BITS = 32 * LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_we,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    input  logic                 dcache_uncached,
    output logic [31:0]          data_sram_rdata,
    output logic                 stallreq_dcache,
    output logic                 mem_rd_req,
    output logic [31:0]          mem_rd_addr,
    output logic                 mem_rd_single,
    input  logic                 mem_rd_valid,
    input  logic [LINE_BITS-1:0] mem_rd_data,
    output logic                 mem_wr_req,
    output logic [31:0]          mem_wr_addr,
    output logic                 mem_wr_single,
    output logic [3:0]           mem_wr_strb,
    output logic [LINE_BITS-1:0] mem_wr_data,
    input  logic                 mem_wr_done
);
    localparam int OFF  = $clog2(LINE_WORDS) + 2;
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 32 - OFF - IDX;
    localparam int WOFF = OFF - 2;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, WB, REFILL, UC_RD, UC_WR, UC_DONE} state_t;
    state_t state;

    logic                 valid [WAYS][SETS];
    logic                 dirty [WAYS][SETS];
    logic [TAGW-1:0]      tags  [WAYS][SETS];
    logic [LINE_BITS-1:0] lines [WAYS][SETS];
    logic [WW-1:0]        ptr   [SETS];

    logic [TAGW-1:0] tag;
    logic [IDX-1:0]  idx;
    logic [WOFF-1:0] word;
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic [WW-1:0]   victim;
    logic [WW-1:0]   vic_way;
    logic [31:0]     uc_word;
    logic [31:0]     old_word;
    logic [31:0]     wmerge;
    logic [31:0]     line_addr;
    logic [31:0]     vic_addr;
    logic            write_hit;
    logic            unused;

    assign tag    = data_sram_addr[31:OFF+IDX];
    assign idx    = data_sram_addr[OFF+IDX-1:OFF];
    assign word   = data_sram_addr[OFF-1:2];
    assign unused = ^data_sram_addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][idx] && tags[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        hit = hit & data_sram_en & ~dcache_uncached;
    end

    // Lowest invalid way wins; the pointer only matters for a full set.
    always_comb begin
        victim = ptr[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][idx]) victim = WW'(w);
        end
    end

    assign old_word  = lines[hit_way][idx][{word, 5'b0} +: 32];
    assign line_addr = {tag, idx, {OFF{1'b0}}};
    assign vic_addr  = {tags[victim][idx], idx, {OFF{1'b0}}};
    assign write_hit = (state == IDLE) && hit && (data_sram_we != 4'b0);

    always_comb begin
        wmerge = old_word;
        for (int b = 0; b < 4; b++) begin
            if (data_sram_we[b]) wmerge[b*8 +: 8] = data_sram_wdata[b*8 +: 8];
        end
    end

    always_comb begin
        data_sram_rdata = '0;
        if (state == UC_DONE) data_sram_rdata = uc_word;
        else if (state == IDLE && hit) data_sram_rdata = old_word;
    end

    assign stallreq_dcache = (state != IDLE && state != UC_DONE) ||
                             (state == IDLE && data_sram_en &&
                              (dcache_uncached || !hit));

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_rd_valid) begin
            lines[vic_way][idx] <= mem_rd_data;
            tags[vic_way][idx]  <= tag;
        end else if (write_hit) begin
            lines[hit_way][idx][{word, 5'b0} +: 32] <= wmerge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            vic_way       <= '0;
            uc_word       <= '0;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            mem_rd_single <= 1'b0;
            mem_wr_req    <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_single <= 1'b0;
            mem_wr_strb   <= '0;
            mem_wr_data   <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid[w][s] <= 1'b0;
                    dirty[w][s] <= 1'b0;
                end
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_sram_en && dcache_uncached) begin
                        if (data_sram_we == 4'b0) begin
                            mem_rd_req    <= 1'b1;
                            mem_rd_single <= 1'b1;
                            mem_rd_addr   <= {data_sram_addr[31:2], 2'b00};
                            state         <= UC_RD;
                        end else begin
                            mem_wr_req    <= 1'b1;
                            mem_wr_single <= 1'b1;
                            mem_wr_addr   <= {data_sram_addr[31:2], 2'b00};
                            mem_wr_strb   <= data_sram_we;
                            mem_wr_data   <= LINE_BITS'(data_sram_wdata);
                            state         <= UC_WR;
                        end
                    end else if (write_hit) begin
                        dirty[hit_way][idx] <= 1'b1;
                    end else if (data_sram_en && !hit) begin
                        vic_way <= victim;
                        if (valid[victim][idx] && dirty[victim][idx]) begin
                            mem_wr_req    <= 1'b1;
                            mem_wr_single <= 1'b0;
                            mem_wr_addr   <= vic_addr;
                            mem_wr_strb   <= 4'b1111;
                            mem_wr_data   <= lines[victim][idx];
                            state         <= WB;
                        end else begin
                            mem_rd_req    <= 1'b1;
                            mem_rd_single <= 1'b0;
                            mem_rd_addr   <= line_addr;
                            state         <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (mem_wr_done) begin
                        mem_wr_req    <= 1'b0;
                        mem_rd_req    <= 1'b1;
                        mem_rd_single <= 1'b0;
                        mem_rd_addr   <= line_addr;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rd_valid) begin
                        mem_rd_req          <= 1'b0;
                        valid[vic_way][idx] <= 1'b1;
                        dirty[vic_way][idx] <= 1'b0;
                        ptr[idx] <= (WAYS > 1) ? ptr[idx] + WW'(1) : '0;
                        state               <= IDLE;
                    end
                end
                UC_RD: begin
                    if (mem_rd_valid) begin
                        mem_rd_req <= 1'b0;
                        uc_word    <= mem_rd_data[31:0];
                        state      <= UC_DONE;
                    end
                end
                UC_WR: begin
                    if (mem_wr_done) begin
                        mem_wr_req <= 1'b0;
                        state      <= UC_DONE;
                    end
                end
                UC_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway: directed vector table, reset corner cases and a
// randomized run against a FIFO-residency / flat-memory reference.
module tb_dcache_nway;
    localparam int LW = 16;
    localparam int LB = 32 * LW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          data_sram_en = 1'b0;
    logic [3:0]    data_sram_we = '0;
    logic [31:0]   data_sram_addr = '0;
    logic [31:0]   data_sram_wdata = '0;
    logic          dcache_uncached = 1'b0;
    logic [31:0]   data_sram_rdata;
    logic          stallreq_dcache;
    logic          mem_rd_req;
    logic [31:0]   mem_rd_addr;
    logic          mem_rd_single;
    logic          mem_rd_valid = 1'b0;
    logic [LB-1:0] mem_rd_data = '0;
    logic          mem_wr_req;
    logic [31:0]   mem_wr_addr;
    logic          mem_wr_single;
    logic [3:0]    mem_wr_strb;
    logic [LB-1:0] mem_wr_data;
    logic          mem_wr_done = 1'b0;

    dcache_nway dut (
        .clk(clk), .reset(reset),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .dcache_uncached(dcache_uncached), .data_sram_rdata(data_sram_rdata),
        .stallreq_dcache(stallreq_dcache),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_single(mem_rd_single), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_single(mem_wr_single), .mem_wr_strb(mem_wr_strb),
        .mem_wr_data(mem_wr_data), .mem_wr_done(mem_wr_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int n_rd = 0;
    int n_wr = 0;
    int max_delay = 0;
    int rd_wait = 0;
    int wr_wait = 0;
    bit hold_rd = 1'b0;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] view [logic [31:0]];

    typedef struct {
        logic [31:0] addr; logic single; logic [3:0] strb; logic [LB-1:0] data;
    } wr_t;
    typedef struct { logic [31:0] addr; logic single; } rd_t;
    wr_t wr_log[$];
    rd_t rd_log[$];

    typedef struct {
        logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; logic uc;
        logic chk; logic [31:0] rdata; int waits; int nrd; int nwr;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] w,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] view_get(input logic [31:0] a);
        return view.exists(a) ? view[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Memory/bridge model: answers held requests after 0..max_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_wr_done  = 1'b0;
            if (!reset) begin
                check("rd_wr_exclusive", {31'b0, mem_rd_req & mem_wr_req}, 0);
                if (mem_rd_req && !hold_rd) begin
                    if (rd_wait == 0) begin
                        rd_log.push_back('{mem_rd_addr, mem_rd_single});
                        mem_rd_data = '0;
                        if (mem_rd_single) mem_rd_data[31:0] = mem_get(mem_rd_addr);
                        else for (int i = 0; i < LW; i++)
                            mem_rd_data[i*32 +: 32] = mem_get(mem_rd_addr + 32'(i*4));
                        mem_rd_valid = 1'b1;
                        n_rd++;
                        rd_wait = $urandom_range(0, max_delay);
                    end else rd_wait--;
                end
                if (mem_wr_req) begin
                    if (wr_wait == 0) begin
                        wr_log.push_back('{mem_wr_addr, mem_wr_single, mem_wr_strb, mem_wr_data});
                        if (mem_wr_single)
                            mem[mem_wr_addr] = merge(mem_get(mem_wr_addr),
                                                     mem_wr_data[31:0], mem_wr_strb);
                        else for (int i = 0; i < LW; i++)
                            mem[mem_wr_addr + 32'(i*4)] = mem_wr_data[i*32 +: 32];
                        mem_wr_done = 1'b1;
                        n_wr++;
                        wr_wait = $urandom_range(0, max_delay);
                    end else wr_wait--;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the access is consumed.
    task automatic access(input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] wd, input logic uc,
                          output logic [31:0] rd, output int waits,
                          output int nrd, output int nwr);
        int r0, w0;
        r0 = n_rd;
        w0 = n_wr;
        data_sram_en    = 1'b1;
        data_sram_addr  = a;
        data_sram_we    = we;
        data_sram_wdata = wd;
        dcache_uncached = uc;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!stallreq_dcache) break;
            waits++;
            if (waits > 200) begin
                checks++;
                fails++;
                $display("FAIL timeout: addr %h still stalled after %0d cycles", a, waits);
                break;
            end
        end
        rd  = data_sram_rdata;
        nrd = n_rd - r0;
        nwr = n_wr - w0;
        @(posedge clk);
        #1;
        data_sram_en    = 1'b0;
        data_sram_we    = '0;
        dcache_uncached = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int waits, nrd, nwr;
        int unsigned res_q [128][$];
        bit dirty_m [logic [31:0]];

        mem[32'h0000_1000] = 32'hA5A5_0001;
        mem[32'h0000_1004] = 32'hFFFF_FFFF;
        mem[32'h1FD0_0000] = 32'hDEAD_BEEF;

        vecs.push_back('{32'h0000_1000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001, 2, 1, 0});
        vecs.push_back('{32'h0000_1004, 4'h3, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 0, 0, 0});
        vecs.push_back('{32'h0000_1004, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_5678, 0, 0, 0});
        vecs.push_back('{32'h0000_3000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hC0DE_3000, 2, 1, 0});
        vecs.push_back('{32'h0000_5000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hC0DE_5000, 3, 1, 1});
        vecs.push_back('{32'h0000_1000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001, 2, 1, 0});
        vecs.push_back('{32'h0000_1004, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_5678, 0, 0, 0});
        vecs.push_back('{32'h0000_3000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hC0DE_3000, 2, 1, 0});
        vecs.push_back('{32'h1FD0_0000, 4'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2, 1, 0});
        vecs.push_back('{32'h1FD0_0004, 4'h8, 32'hAB00_0000, 1'b1, 1'b0, 32'h0, 2, 0, 1});
        vecs.push_back('{32'h0000_1004, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 0, 0, 0});
        vecs.push_back('{32'h0000_1004, 4'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_5678, 2, 1, 0});
        vecs.push_back('{32'h0000_1004, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 0, 0, 0});
        vecs.push_back('{32'h0000_1004, 4'hF, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 2, 0, 1});
        vecs.push_back('{32'h0000_1004, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 0, 0, 0});

        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'b0, stallreq_dcache}, 0);
        check("rst_rdata", data_sram_rdata, 0);
        check("rst_rd_req", {31'b0, mem_rd_req}, 0);
        check("rst_wr_req", {31'b0, mem_wr_req}, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_singles", {30'b0, mem_rd_single, mem_wr_single}, 0);
        check("rst_wr_strb", {28'b0, mem_wr_strb}, 0);
        check("rst_wr_data", {31'b0, |mem_wr_data}, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].uc,
                   rd, waits, nrd, nwr);
            check($sformatf("vec%0d_stall_cycles", i), waits, vecs[i].waits);
            check($sformatf("vec%0d_line_reads", i), nrd, vecs[i].nrd);
            check($sformatf("vec%0d_writes", i), nwr, vecs[i].nwr);
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end

        check("wr_log_size", wr_log.size(), 3);
        if (wr_log.size() >= 2) begin
            check("wb_addr", wr_log[0].addr, 32'h0000_1000);
            check("wb_single", {31'b0, wr_log[0].single}, 0);
            check("wb_strb", {28'b0, wr_log[0].strb}, 4'hF);
            check("wb_word0", wr_log[0].data[31:0], 32'hA5A5_0001);
            check("wb_word1", wr_log[0].data[63:32], 32'hFFFF_5678);
            check("ucw_addr", wr_log[1].addr, 32'h1FD0_0004);
            check("ucw_single", {31'b0, wr_log[1].single}, 1);
            check("ucw_strb", {28'b0, wr_log[1].strb}, 4'h8);
            check("ucw_data", wr_log[1].data[31:0], 32'hAB00_0000);
        end
        check("rd_log_size", rd_log.size(), 7);
        if (rd_log.size() >= 6) begin
            check("refill_addr", rd_log[0].addr, 32'h0000_1000);
            check("refill_single", {31'b0, rd_log[0].single}, 0);
            check("ucr_addr", rd_log[5].addr, 32'h1FD0_0000);
            check("ucr_single", {31'b0, rd_log[5].single}, 1);
        end

        // Reset asserted while a refill is outstanding.
        hold_rd         = 1'b1;
        data_sram_en    = 1'b1;
        data_sram_addr  = 32'h0000_2000;
        data_sram_we    = '0;
        dcache_uncached = 1'b0;
        @(posedge clk);
        #1;
        check("refill_req_held", {31'b0, mem_rd_req}, 1);
        check("refill_req_addr", mem_rd_addr, 32'h0000_2000);
        #2 reset = 1'b1;
        #1;
        check("rst_drops_req", {31'b0, mem_rd_req}, 0);
        data_sram_en = 1'b0;
        @(negedge clk) begin
            reset   = 1'b0;
            hold_rd = 1'b0;
        end
        @(posedge clk);
        #1;
        access(32'h0000_2000, 4'h0, 32'h0, 1'b0, rd, waits, nrd, nwr);
        check("post_rst_miss_stall", waits, 2);
        check("post_rst_miss_reads", nrd, 1);
        check("post_rst_miss_rdata", rd, 32'hC0DE_2000);
        access(32'h0000_1004, 4'h0, 32'h0, 1'b0, rd, waits, nrd, nwr);
        check("post_rst_cold_reads", nrd, 1);
        check("post_rst_dirty_dropped", rd, 32'h1111_1111);

        // Randomized run from an empty cache.
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        max_delay = 3;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, wd, exp, vline;
            logic [LB-1:0] eline;
            logic [3:0] we;
            logic uc, res, evd;
            int s, t;
            uc = ($urandom_range(0, 4) == 0);
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wd = $urandom;
            s = 37 * $urandom_range(0, 3);
            t = 16 + $urandom_range(0, 3);
            if (uc) a = 32'h1FD0_0100 + 32'($urandom_range(0, 15)) * 4;
            else a = (32'(t) << 13) | (32'(s) << 6) | (32'($urandom_range(0, 15)) << 2);
            exp   = view_get(a);
            res   = 1'b0;
            evd   = 1'b0;
            vline = '0;
            eline = '0;
            if (!uc) begin
                for (int i = 0; i < res_q[s].size(); i++)
                    if (res_q[s][i] == t) res = 1'b1;
                if (!res) begin
                    if (res_q[s].size() == 2) begin
                        vline = (32'(res_q[s].pop_front()) << 13) | (32'(s) << 6);
                        evd = dirty_m.exists(vline);
                        if (evd) dirty_m.delete(vline);
                        for (int i = 0; i < LW; i++)
                            eline[i*32 +: 32] = view_get(vline + 32'(i*4));
                    end
                    res_q[s].push_back(t);
                end
                if (we != 0) dirty_m[a & ~32'h3F] = 1'b1;
            end
            if (we != 0) view[a] = merge(exp, wd, we);
            access(a, we, wd, uc, rd, waits, nrd, nwr);
            if (uc) begin
                check("rnd_uc_stall", {31'b0, waits >= 2}, 1);
                check("rnd_uc_reads", nrd, (we == 0) ? 1 : 0);
                check("rnd_uc_writes", nwr, (we == 0) ? 0 : 1);
            end else begin
                check("rnd_hit", {31'b0, waits == 0}, {31'b0, res});
                check("rnd_reads", nrd, res ? 0 : 1);
                check("rnd_writebacks", nwr, evd ? 1 : 0);
                if (evd && wr_log.size() > 0) begin
                    check("rnd_wb_addr", wr_log[$].addr, vline);
                    checks++;
                    if (wr_log[$].data !== eline) begin
                        fails++;
                        $display("FAIL rnd_wb_line: line %h got %h, required %h",
                                 vline, wr_log[$].data[63:0], eline[63:0]);
                    end
                end
            end
            if (we == 0) check("rnd_rdata", rd, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
